// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store unit bridging the pipeline to a single-beat
//            Wishbone-style bus, with lane formatting, misalign and timeout.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [1:0]  mem_type,
    input  logic        mem_ext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_unalign,
    output logic        mem_timeout,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_addr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dout,
    input  logic [31:0] wb_din,
    input  logic        wb_ack
);

    localparam int unsigned c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Timeout fires on the edge where the counter would step onto TIMEOUT.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_stall;
    logic                w_unalign;
    logic                w_start;
    logic                w_req;
    logic                w_misalign;
    logic                w_tmo_hit;
    logic [31:0]         w_wdata;
    logic [3:0]          w_sel;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;

    logic [31:0]         r_addr;
    logic [1:0]          r_type;
    logic                r_ext;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [3:0]          r_sel;
    logic [31:0]         r_rdata;
    logic                r_cyc;
    logic                r_tmo;
    logic [c_CNT_W-1:0]  r_cnt;

    assign w_req      = mem_ren | mem_wen;
    assign w_misalign = ((mem_type == 2'b01) && mem_addr[0]) ||
                        (mem_type[1] && (mem_addr[1:0] != 2'b00));
    assign w_tmo_hit  = (TIMEOUT != 0) && (r_state == S_BUSY) && !wb_ack &&
                        (r_cnt == c_CNT_LAST);

    // Store lane replication and byte-enable generation
    always_comb begin
        w_wdata = mem_dout;
        w_sel   = 4'b1111;
        case (mem_type)
            2'b00: begin
                w_wdata = {4{mem_dout[7:0]}};
                w_sel   = 4'b0001 << mem_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{mem_dout[15:0]}};
                w_sel   = 4'b0011 << {mem_addr[1], 1'b0};
            end
            default: begin
                w_wdata = mem_dout;
                w_sel   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_unalign = 1'b0;
        w_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_misalign) begin
                        w_unalign = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                        w_start = 1'b1;
                        w_next  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (wb_ack || w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_type  <= '0;
            r_ext   <= 1'b0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_cyc   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_tmo <= 1'b0;
            if (w_start) begin
                r_addr  <= mem_addr;
                r_type  <= mem_type;
                r_ext   <= mem_ext;
                r_we    <= mem_wen;
                r_wdata <= w_wdata;
                r_sel   <= w_sel;
                r_cyc   <= 1'b1;
                r_cnt   <= '0;
            end else if (r_state == S_BUSY) begin
                // Ack takes precedence over an expiring counter
                if (wb_ack) begin
                    r_rdata <= wb_din;
                    r_cyc   <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_rdata <= '0;
                    r_cyc   <= 1'b0;
                    r_tmo   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Load lane selection and extension
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = r_rdata[7:0];
            2'b01:   w_byte = r_rdata[15:8];
            2'b10:   w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_type)
            2'b00:   w_load = {{24{r_ext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_ext & w_half[15]}}, w_half};
            default: w_load = r_rdata;
        endcase
    end

    assign mem_din     = (r_state == S_DONE) ? w_load : 32'h0;
    assign mem_stall   = w_stall;
    assign mem_unalign = w_unalign;
    assign mem_timeout = r_tmo;
    assign wb_cyc      = r_cyc;
    assign wb_stb      = r_cyc;
    assign wb_we       = r_we;
    assign wb_addr     = {r_addr[31:2], 2'b00};
    assign wb_sel      = r_sel;
    assign wb_dout     = r_wdata;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high, on ports clk and rst.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the bus-wait cycle limit; 0 disables the timeout.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 mem_ren  in  1  load request from the MEM stage.
REQ-006 mem_wen  in  1  store request from the MEM stage.
REQ-007 mem_type  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 mem_ext  in  1  load result is sign-extended (1) or zero-extended (0).
REQ-009 mem_addr  in  32  byte address of the access.
REQ-010 mem_dout  in  32  store data, right-aligned.
REQ-011 mem_din  out  32  load result, right-aligned and extended.
REQ-012 mem_stall  out  1  holds the pipeline while an access is outstanding.
REQ-013 mem_unalign  out  1  misaligned-access exception flag.
REQ-014 mem_timeout  out  1  one-cycle bus-timeout exception pulse.
REQ-015 wb_cyc, wb_stb  out  1 each  bus cycle and strobe.
REQ-016 wb_we  out  1  bus write enable.
REQ-017 wb_addr  out  32  word address {addr[31:2],2'b00}.
REQ-018 wb_sel  out  4  byte lane enables; lane n is bits [8n+7:8n] (little-endian).
REQ-019 wb_dout  out  32  bus write data.
REQ-020 wb_din  in  32  bus read data.
REQ-021 wb_ack  in  1  bus acknowledge.

Function
REQ-022 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-023 A request is present when (mem_ren|mem_wen) is 1; if mem_wen=1 the request is a store, and mem_wen has priority over mem_ren.
REQ-024 A request is misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-025 In IDLE with an aligned request: mem_stall=1 combinationally, and the block SHALL register addr, type, ext, we and formatted store data, then enter BUSY.
REQ-026 In IDLE with a misaligned request: mem_unalign=1 combinationally, mem_stall=0, mem_din=0, no bus cycle, and the state stays IDLE.
REQ-027 In BUSY: wb_cyc=wb_stb=1, mem_stall=1, and all wb_* outputs SHALL be driven only from registers so they stay stable until ack.
REQ-028 In BUSY, when wb_ack=1: latch wb_din into rdata, drop cyc/stb on the next edge, and enter DONE.
REQ-029 In DONE: mem_stall=0 and mem_din=formatted rdata; the block SHALL return to IDLE unconditionally on the next edge.
REQ-030 Minimum latency is 3 cycles (IDLE, BUSY, DONE) with a same-cycle ack; each extra cycle of ack delay adds one cycle.
REQ-031 Store formatting: byte data SHALL be replicated to all 4 lanes with wb_sel=4'b0001<<addr[1:0]; half data to both halves with wb_sel=4'b0011<<{addr[1],1'b0}; word with wb_sel=4'b1111.
REQ-032 For loads, wb_sel SHALL be formed identically to stores and wb_dout is don't-care.
REQ-033 Load formatting: select the byte or half at addr[1:0], then extend to 32 bits per mem_ext; a word load passes through unchanged.
REQ-034 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-035 If TIMEOUT!=0 and the counter reaches TIMEOUT: drop cyc/stb, pulse mem_timeout for 1 cycle, set rdata=0, and enter DONE.
REQ-036 If ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win and there is no timeout.
REQ-037 wb_ack SHALL be ignored in IDLE and DONE.
REQ-038 Request inputs SHALL be ignored in BUSY and DONE, since their values were captured on IDLE exit.
REQ-039 mem_din SHALL be 0 in IDLE and BUSY.

Reset
REQ-040 When rst=1, asynchronously: state=IDLE, wb_cyc=wb_stb=wb_we=0, wb_sel=0, wb_addr=0, wb_dout=0, rdata=0, counter=0, mem_timeout=0.
REQ-041 After reset, mem_stall and mem_unalign SHALL follow the IDLE combinational rules.
REQ-042 Reset asserted mid-BUSY SHALL abandon the bus cycle immediately, and a later ack SHALL be ignored.

Verification
REQ-043 Byte load sign-extend: mem_ren=1, type=00, ext=1, addr=0x1003, wb_din=0x80AA_BBCC, ack on the 1st BUSY cycle -> wb_sel=1000, wb_addr=0x1000, stall for 2 cycles, then mem_din=0xFFFF_FF80 in DONE.
REQ-044 Half store: mem_wen=1, type=01, addr=0x2002, mem_dout=0x1234_5678 -> wb_we=1, wb_sel=1100, wb_dout=0x5678_5678.
REQ-045 Misaligned: word load, addr=0x0000_0006 -> mem_unalign=1, mem_stall=0, wb_cyc stays 0.
REQ-046 Timeout: TIMEOUT=4, no ack -> wb_cyc high for 4 cycles, mem_timeout pulses once, mem_din=0 in DONE, then IDLE.
REQ-047 Reset mid-access: assert rst during BUSY -> wb_cyc=0 in the same cycle; an ack driven after reset release leaves the state IDLE.
REQ-048 Back-to-back: two word loads with stalled request inputs held -> two bus cycles, with the DONE->IDLE gap observed between them.
